// File: rtl/axi_sram_subordinate.sv
// AXI-style subordinate backed by a word-addressed register-array SRAM.
// Independent write (aw/w/b) and read (ar/r) FSMs allow one of each in flight.
module axi_sram_subordinate #(
  parameter int MEM_AW    = 10,
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [5:0]  awatop,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [3:0]  bid,
  output logic        bcomp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic        rlast
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  logic [31:0]       mem [0:(1<<MEM_AW)-1];

  logic [1:0]        w_state;
  logic [3:0]        w_id;
  logic [MEM_AW-1:0] w_idx;

  logic [1:0]        r_state;
  logic [3:0]        r_id;
  logic [MEM_AW-1:0] r_idx;
  logic [BW-1:0]     r_beat;

  // Address bits outside the word index and the atomic opcode are ignored.
  logic unused_ok;
  assign unused_ok = ^{awatop, awaddr[31:MEM_AW+2], awaddr[1:0],
                       araddr[31:MEM_AW+2], araddr[1:0]};

  // All handshake outputs decode from state; ids come from capture registers.
  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bcomp   = (w_state == W_RESP);
  assign bid     = w_id;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign rid     = r_id;
  assign rlast   = (r_state == R_DATA) && (r_beat == BW'(BURST_LEN - 1));

  // NOTE: non-blocking assignments in every clocked block, so a fetch in the
  // same cycle as a write to that word samples the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_idx   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_id    <= awid;
          w_idx   <= awaddr[MEM_AW+1:2];
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_idx <= w_idx + MEM_AW'(1);
          if (wlast) w_state <= W_RESP;
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; only control
  // state clears, and contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_state == W_DATA && wvalid) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_idx   <= '0;
      r_beat  <= '0;
      rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_id    <= arid;
          r_idx   <= araddr[MEM_AW+1:2];
          r_beat  <= '0;
          r_state <= R_FETCH;
        end
        R_FETCH: begin
          rdata   <= mem[r_idx];
          r_state <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            r_state <= R_IDLE;
          end else begin
            r_idx   <= r_idx + MEM_AW'(1);
            r_beat  <= r_beat + BW'(1);
            r_state <= R_FETCH;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_subordinate.sv
// Directed bench for axi_sram_subordinate: table of single-word writes with
// read-back, plus hand sequences for bursts, stalls, wrap, overlap and reset.
module tb_axi_sram_subordinate;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [5:0]  awatop = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b0;
  logic [3:0]  bid;
  logic        bcomp;
  logic        arvalid = 1'b0, arready;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;

  axi_sram_subordinate #(.MEM_AW(10), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awatop(awatop),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bcomp(bcomp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [BL];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int n);
    int cyc;
    awvalid = 1'b1; awid = id; awaddr = addr;
    cyc = 0;
    while (!awready && cyc < 20) begin tick(); cyc++; end
    check("aw_timeout", 32'(cyc < 20), 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == n - 1);
      check("wready", 32'(wready), 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("wready_after_last", 32'(wready), 0);
    check("bvalid", 32'(bvalid), 1);
    check("bcomp", 32'(bcomp), 1);
    check("bid", 32'(bid), 32'(id));
    tick();
    check("bvalid_hold", 32'(bvalid), 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_clear", 32'(bvalid), 0);
    check("awready_back", 32'(awready), 1);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int stall);
    int cyc;
    logic [31:0] held;
    arvalid = 1'b1; arid = id; araddr = addr;
    cyc = 0;
    while (!arready && cyc < 20) begin tick(); cyc++; end
    check("ar_timeout", 32'(cyc < 20), 1);
    tick();
    arvalid = 1'b0;
    for (int b = 0; b < BL; b++) begin
      cyc = 0;
      while (!rvalid && cyc < 10) begin tick(); cyc++; end
      check("r_timeout", 32'(cyc < 10), 1);
      if (b == 0) check("r_latency", 32'(cyc), 1);
      held = rdata;
      for (int s = 0; s < stall; s++) begin
        tick();
        check("r_stall_valid", 32'(rvalid), 1);
        check("r_stall_data", rdata, held);
      end
      check("rid", 32'(rid), 32'(id));
      check("rlast", 32'(rlast), 32'(b == BL - 1));
      rbuf[b] = rdata;
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    check("arready_back", 32'(arready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0400, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD};
    vecs[1] = '{32'h0000_0400, 32'h1122_3344, 4'h5, 32'hAA22_CC44};
    vecs[2] = '{32'h0000_0400, 32'h5566_7788, 4'hA, 32'h5522_7744};
    vecs[3] = '{32'h0000_0404, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
    vecs[4] = '{32'h0000_0405, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
    vecs[5] = '{32'h8000_0407, 32'h1234_5678, 4'hC, 32'h1234_BEEF};
    vecs[6] = '{32'h0000_0200, 32'hCAFE_0000, 4'hF, 32'hCAFE_0000};

    tick(); tick();
    check("rst_awready", 32'(awready), 1);
    check("rst_arready", 32'(arready), 1);
    check("rst_wready", 32'(wready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_bcomp", 32'(bcomp), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rlast", 32'(rlast), 0);
    check("rst_bid", 32'(bid), 0);
    check("rst_rid", 32'(rid), 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();

    // Full-strobe 4-beat write, then read back with 3-cycle stalls per beat.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'h1111_1111 * (i + 1);
      sbuf[i] = 4'hF;
    end
    write_burst(4'd3, 32'h0000_0100, 4);
    read_burst(4'd5, 32'h0000_0100, 3);
    for (int i = 0; i < 4; i++) check("burst_data", rbuf[i], 32'h1111_1111 * (i + 1));

    // Single-beat writes with strobes and address aliasing.
    for (int v = 0; v < 7; v++) begin
      wbuf[0] = vecs[v].data;
      sbuf[0] = vecs[v].strb;
      write_burst(4'(v), vecs[v].addr, 1);
      read_burst(4'(v + 8), vecs[v].addr, 0);
      check("vec_readback", rbuf[0], vecs[v].exp);
    end

    // Wrap-around: words 1022, 1023, 0, 1 written and read as one burst.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hA000_0000 + 32'(i);
      sbuf[i] = 4'hF;
    end
    write_burst(4'd1, 32'h0000_0FF8, 4);
    read_burst(4'd2, 32'h7000_0FFB, 0);
    for (int i = 0; i < 4; i++) check("wrap_data", rbuf[i], 32'hA000_0000 + 32'(i));
    read_burst(4'd2, 32'h0000_0000, 0);
    check("wrap_word0", rbuf[0], 32'hA000_0002);
    check("wrap_word1", rbuf[1], 32'hA000_0003);

    // Overlapping write and read of 0x200: beat 0 fetch collides with w beat 0.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hB000_0000 + 32'(i);
      sbuf[i] = 4'hF;
    end
    fork
      write_burst(4'd6, 32'h0000_0200, 4);
      read_burst(4'd7, 32'h0000_0200, 0);
    join
    check("overlap_beat0_old", rbuf[0], 32'hCAFE_0000);
    for (int i = 1; i < 4; i++) check("overlap_beat_new", rbuf[i], 32'hB000_0000 + 32'(i));
    read_burst(4'd7, 32'h0000_0200, 0);
    for (int i = 0; i < 4; i++) check("overlap_later", rbuf[i], 32'hB000_0000 + 32'(i));

    // Reset after two write beats aborts the burst with no response.
    awvalid = 1'b1; awid = 4'd7; awaddr = 32'h0000_0300;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wstrb = 4'hF; wlast = 1'b0; wdata = 32'hC0DE_0001;
    tick();
    wdata = 32'hC0DE_0002;
    tick();
    wvalid = 1'b0;
    check("pre_reset_wready", 32'(wready), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wready", 32'(wready), 0);
    check("mid_rst_bvalid", 32'(bvalid), 0);
    check("mid_rst_awready", 32'(awready), 1);
    check("mid_rst_arready", 32'(arready), 1);
    check("mid_rst_bid", 32'(bid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_bvalid", 32'(bvalid), 0);
    read_burst(4'd4, 32'h0000_0300, 0);
    check("post_rst_mem0", rbuf[0], 32'hC0DE_0001);
    check("post_rst_mem1", rbuf[1], 32'hC0DE_0002);
    wbuf[0] = 32'h600D_F00D;
    sbuf[0] = 4'hF;
    write_burst(4'd9, 32'h0000_0308, 1);
    read_burst(4'd9, 32'h0000_0308, 0);
    check("post_rst_write", rbuf[0], 32'h600D_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_subordinate.md
Name: axi_sram_subordinate

Overview:
- Subordinate (responder) end of the team's 32-bit AXI-style bus: the target of `axi_bus_top`'s aw/w/b/ar/r manager channels.
- Backs the bus with an internal word-addressed register-array SRAM.
- Write path takes one address, then data beats until wlast, then returns one response. Read path returns BURST_LEN beats per address with rlast on the final beat.
- Write and read FSMs are independent, so one write and one read may be in flight concurrently.

Parameters:
- MEM_AW, 10, word-address width; memory depth is 2^MEM_AW 32-bit words.
- BURST_LEN, 4, read beats per ar request (4 beats = one 128-bit cache line).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- awvalid  in  1  write request valid
- awready  out  1  write request accepted
- awid  in  4  write transaction id
- awaddr  in  32  write byte address
- awatop  in  6  atomic opcode, ignored
- wvalid  in  1  write beat valid
- wready  out  1  write beat accepted
- wdata  in  32  write beat data
- wstrb  in  4  byte enables, bit n covers wdata[8n+7:8n]
- wlast  in  1  final write beat
- bvalid  out  1  write response valid
- bready  in  1  response accepted
- bid  out  4  echoed awid
- bcomp  out  1  write completed
- arvalid  in  1  read request valid
- arready  out  1  read request accepted
- arid  in  4  read transaction id
- araddr  in  32  read byte address
- rvalid  out  1  read beat valid
- rready  in  1  read beat accepted
- rid  out  4  echoed arid
- rdata  out  32  read beat data
- rlast  out  1  final read beat

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset effect: both FSMs return to IDLE and the id, index and beat registers clear. Memory contents are not reset.
- Reset values of outputs: awready=1, arready=1 (decoded from IDLE). wready, bvalid, bcomp, rvalid and rlast are 0. bid, rid and rdata are 0.
- Reset mid-burst aborts the burst immediately. There is no response for an aborted burst.
- Address mapping: word index = addr[MEM_AW+1:2]. Bits [1:0] and bits above MEM_AW+1 are ignored, so addresses alias. The index increments by 1 per beat, modulo 2^MEM_AW, so bursts wrap from the top word to word 0.
- Write FSM W_IDLE: awready=1. When awvalid is high, capture awid and the index, then go to W_DATA.
- Write FSM W_DATA: wready=1. On each cycle with wvalid high:
  - each byte of mem[index] whose wstrb bit is 1 is written; bytes with wstrb=0 are unchanged;
  - index increments;
  - if wlast is also high, go to W_RESP.
  - Beat count is not checked: wlast alone ends the burst, and any number of beats is accepted.
- Write FSM W_RESP: bvalid=1, bcomp=1, bid=captured id. Hold these until bready is high, then go to W_IDLE. awready returns to 1 in the cycle after the handshake.
- Read FSM R_IDLE: arready=1. When arvalid is high, capture arid and the index, clear the beat counter, then go to R_FETCH.
- Read FSM R_FETCH: one cycle. Register mem[index] into rdata, then go to R_DATA.
- Read FSM R_DATA: rvalid=1, rid=captured id, rlast=(beat==BURST_LEN-1). rdata, rid and rlast stay stable while rready is low. When rready is high:
  - if rlast, go to R_IDLE;
  - otherwise increment index and beat and go to R_FETCH.
- Read latency: first rvalid 2 cycles after the ar handshake. Steady-state throughput is 1 beat per 2 cycles with no backpressure.
- Concurrent access: the FSMs run independently. If R_FETCH and a w handshake target the same word in the same cycle, the read returns the pre-write data. Write data becomes visible to fetches from the next cycle.
- Outputs: all outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

Test Plan:
- Full-strobe write: aw (awid=3, addr 0x100), 4 beats 0x11111111..0x44444444 with wstrb=F and wlast on beat 4 -> exactly 4 wready handshakes, then bvalid=1 with bid=3, bcomp=1. Words 0x40..0x43 hold the data.
- Read back with backpressure: ar (arid=5, addr 0x100), rready low for 3 cycles per beat -> 4 beats in order, rid=5, rlast only on beat 4. rdata stays stable while stalled. First rvalid arrives 2 cycles after the ar handshake.
- Partial strobes: word holds 0xAABBCCDD, single-beat write of 0x11223344 with wstrb=0101 and wlast=1 -> readback 0xAA22CC44.
- Wrap-around: read at the word index 2^MEM_AW-2 -> beats return words 1022, 1023, 0, 1 (MEM_AW=10).
- Concurrent write and read: a write burst to 0x200 overlaps a read of 0x200 with the fetch colliding on beat 0 -> that beat returns the old value. A later read returns the new data. bvalid and rvalid sequencing are otherwise unaffected.
- Reset mid-burst: assert rst_n=0 after 2 write beats -> wready=0 and bvalid=0, awready=1 and arready=1. A new write after reset completes normally with the correct bid.
